// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes and the default instruction width.
// The state encoding follows the customary 1149.1 binary values, so debug traces read familiar.
package jtag_pkg;

  localparam int unsigned IR_W = 2;

  typedef enum logic [3:0] {
    TapExit2Dr = 4'h0,
    TapExit1Dr = 4'h1,
    TapShiftDr = 4'h2,
    TapPauseDr = 4'h3,
    TapSelIr   = 4'h4,
    TapUpdDr   = 4'h5,
    TapCapDr   = 4'h6,
    TapSelDr   = 4'h7,
    TapExit2Ir = 4'h8,
    TapExit1Ir = 4'h9,
    TapShiftIr = 4'hA,
    TapPauseIr = 4'hB,
    TapRti     = 4'hC,
    TapUpdIr   = 4'hD,
    TapCapIr   = 4'hE,
    TapTlr     = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] EXTEST = '0;
  localparam logic [IR_W-1:0] SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] BYPASS = '1;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// TAP serial inputs and boundary-scan control outputs, bundled between the controller
// (master) and whatever drives tms/tdi and consumes the scan controls (slave).
interface jtag_tap_ctrl_if;

  logic       tms;
  logic       tdi;
  logic       shift_dr;
  logic       up_enable;
  logic       mode;
  logic       sel;
  logic       bp_shift;
  logic       ir_tdo;
  logic       tdo_ir_sel;
  logic [3:0] state;

  modport master (
    input  tms,
    input  tdi,
    output shift_dr,
    output up_enable,
    output mode,
    output sel,
    output bp_shift,
    output ir_tdo,
    output tdo_ir_sel,
    output state
  );

  modport slave (
    output tms,
    output tdi,
    input  shift_dr,
    input  up_enable,
    input  mode,
    input  sel,
    input  bp_shift,
    input  ir_tdo,
    input  tdo_ir_sel,
    input  state
  );

endinterface

// File: rtl/jtag_ir.sv
// Instruction register: a capture/shift stage feeding an active stage that is updated
// from it on leaving UPD_IR and forced to BYPASS whenever the TAP heads into TLR.
module jtag_ir #(
  parameter int unsigned IR_W = jtag_pkg::IR_W
) (
  input  logic            tck,
  input  logic            rst,
  input  logic            i_capture,
  input  logic            i_shift,
  input  logic            i_update,
  input  logic            i_reset_ir,
  input  logic            i_tdi,
  output logic [IR_W-1:0] o_ir,
  output logic            o_tdo
);

  logic [IR_W-1:0] r_shift;
  logic [IR_W-1:0] w_shift_next;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] w_ir_next;

  always_comb begin
    w_shift_next = r_shift;
    if (i_capture) begin
      w_shift_next = IR_W'(1);
    end else if (i_shift) begin
      w_shift_next = {i_tdi, r_shift[IR_W-1:1]};
    end
  end

  // TLR entry wins over update; the two never coincide in a legal walk anyway.
  always_comb begin
    w_ir_next = r_ir;
    if (i_reset_ir) begin
      w_ir_next = {IR_W{1'b1}};
    end else if (i_update) begin
      w_ir_next = r_shift;
    end
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      r_shift <= '0;
      r_ir    <= {IR_W{1'b1}};
    end else begin
      r_shift <= w_shift_next;
      r_ir    <= w_ir_next;
    end
  end

  assign o_ir  = r_ir;
  assign o_tdo = r_shift[0];

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM plus Moore decode of boundary-scan controls
// from the current state and the active instruction.
module jtag_tap_ctrl #(
  parameter int unsigned IR_W = jtag_pkg::IR_W
) (
  input  logic            tck,
  input  logic            rst,
  jtag_tap_ctrl_if.master bus
);

  import jtag_pkg::*;

  tap_state_e      r_state;
  tap_state_e      w_state_next;
  logic [IR_W-1:0] w_ir;
  logic            w_ir_tdo;
  logic            w_capture_ir;
  logic            w_shift_ir;
  logic            w_update_ir;
  logic            w_enter_tlr;
  logic            w_is_extest;
  logic            w_is_sample;
  logic            w_is_bypass;

  always_ff @(posedge tck) begin
    if (rst) begin
      r_state <= TapTlr;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      TapTlr:     w_state_next = bus.tms ? TapTlr     : TapRti;
      TapRti:     w_state_next = bus.tms ? TapSelDr   : TapRti;
      TapSelDr:   w_state_next = bus.tms ? TapSelIr   : TapCapDr;
      TapCapDr:   w_state_next = bus.tms ? TapExit1Dr : TapShiftDr;
      TapShiftDr: w_state_next = bus.tms ? TapExit1Dr : TapShiftDr;
      TapExit1Dr: w_state_next = bus.tms ? TapUpdDr   : TapPauseDr;
      TapPauseDr: w_state_next = bus.tms ? TapExit2Dr : TapPauseDr;
      TapExit2Dr: w_state_next = bus.tms ? TapUpdDr   : TapShiftDr;
      TapUpdDr:   w_state_next = bus.tms ? TapSelDr   : TapRti;
      TapSelIr:   w_state_next = bus.tms ? TapTlr     : TapCapIr;
      TapCapIr:   w_state_next = bus.tms ? TapExit1Ir : TapShiftIr;
      TapShiftIr: w_state_next = bus.tms ? TapExit1Ir : TapShiftIr;
      TapExit1Ir: w_state_next = bus.tms ? TapUpdIr   : TapPauseIr;
      TapPauseIr: w_state_next = bus.tms ? TapExit2Ir : TapPauseIr;
      TapExit2Ir: w_state_next = bus.tms ? TapUpdIr   : TapShiftIr;
      TapUpdIr:   w_state_next = bus.tms ? TapSelDr   : TapRti;
      default:    w_state_next = TapTlr;
    endcase
  end

  assign w_capture_ir = (r_state == TapCapIr);
  assign w_shift_ir   = (r_state == TapShiftIr);
  assign w_update_ir  = (r_state == TapUpdIr);
  assign w_enter_tlr  = (w_state_next == TapTlr);

  jtag_ir #(
    .IR_W (IR_W)
  ) u_ir (
    .tck        (tck),
    .rst        (rst),
    .i_capture  (w_capture_ir),
    .i_shift    (w_shift_ir),
    .i_update   (w_update_ir),
    .i_reset_ir (w_enter_tlr),
    .i_tdi      (bus.tdi),
    .o_ir       (w_ir),
    .o_tdo      (w_ir_tdo)
  );

  // The unassigned opcode falls through to BYPASS.
  assign w_is_extest = (w_ir == IR_W'(EXTEST));
  assign w_is_sample = (w_ir == IR_W'(SAMPLE));
  assign w_is_bypass = !w_is_extest && !w_is_sample;

  always_comb begin
    bus.shift_dr   = 1'b0;
    bus.bp_shift   = 1'b0;
    bus.up_enable  = 1'b0;
    bus.mode       = 1'b0;
    bus.sel        = 1'b0;
    bus.tdo_ir_sel = 1'b0;
    if (r_state == TapShiftDr) begin
      bus.shift_dr = !w_is_bypass;
      bus.bp_shift = w_is_bypass;
    end
    if (r_state == TapUpdDr) begin
      bus.up_enable = !w_is_bypass;
    end
    bus.mode       = w_is_extest && (r_state != TapTlr);
    bus.sel        = w_is_bypass;
    bus.tdo_ir_sel = (r_state == TapShiftIr);
  end

  assign bus.ir_tdo = w_ir_tdo;
  assign bus.state  = r_state;

  a_shift_excl: assert property (@(posedge tck) disable iff (rst)
    !(bus.shift_dr && bus.bp_shift));
  a_up_in_upd: assert property (@(posedge tck) disable iff (rst)
    bus.up_enable |-> (r_state == TapUpdDr));

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scenarios with literal expectations, then random tms/tdi/rst
// checked every cycle against a column/stage model of the TAP.
module tb_jtag_tap_ctrl;

  import jtag_pkg::*;

  logic tck;
  logic rst;
  int   n_checks;
  int   n_errors;

  jtag_tap_ctrl_if bus ();

  jtag_tap_ctrl #(
    .IR_W (2)
  ) dut (
    .tck (tck),
    .rst (rst),
    .bus (bus.master)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Model state: 0 = TLR, 1 = RTI, else 2 + column*7 + stage (column 0 = DR, 1 = IR).
  localparam int SEL = 0, CAP = 1, SHF = 2, EX1 = 3, PAU = 4, EX2 = 5, UPD = 6;
  int         m_s;
  logic [1:0] m_sr;
  logic [1:0] m_ir;
  bit         m_valid;

  function automatic int m_col(int s);
    return (s < 2) ? -1 : (s - 2) / 7;
  endfunction

  function automatic int m_stg(int s);
    return (s < 2) ? -1 : (s - 2) % 7;
  endfunction

  function automatic int m_next(int s, bit t);
    if (s == 0) return t ? 0 : 1;
    if (s == 1) return t ? 2 : 1;
    case (m_stg(s))
      SEL:     return t ? ((m_col(s) == 0) ? 9 : 0) : s + 1;
      CAP:     return t ? s + 2 : s + 1;
      SHF:     return t ? s + 1 : s;
      EX1:     return t ? s + 3 : s + 1;
      PAU:     return t ? s + 1 : s;
      EX2:     return t ? s + 1 : s - 3;
      default: return t ? 2 : 1;
    endcase
  endfunction

  function automatic logic [3:0] m_enc(int s);
    case (s)
      0:       return TapTlr;
      1:       return TapRti;
      2:       return TapSelDr;
      3:       return TapCapDr;
      4:       return TapShiftDr;
      5:       return TapExit1Dr;
      6:       return TapPauseDr;
      7:       return TapExit2Dr;
      8:       return TapUpdDr;
      9:       return TapSelIr;
      10:      return TapCapIr;
      11:      return TapShiftIr;
      12:      return TapExit1Ir;
      13:      return TapPauseIr;
      14:      return TapExit2Ir;
      default: return TapUpdIr;
    endcase
  endfunction

  task automatic m_update(bit r, bit t, bit d);
    int nxt;
    if (r) begin
      m_s  = 0;
      m_ir = 2'b11;
      m_sr = 2'b00;
      return;
    end
    nxt = m_next(m_s, t);
    if (m_col(m_s) == 1 && m_stg(m_s) == UPD) m_ir = m_sr;
    if (nxt == 0) m_ir = 2'b11;
    if (m_col(m_s) == 1 && m_stg(m_s) == CAP) m_sr = 2'b01;
    else if (m_col(m_s) == 1 && m_stg(m_s) == SHF) m_sr = {d, m_sr[1]};
    m_s = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge tck) begin
    if (m_valid) begin
      bit dr_shift, dr_upd, ext, smp, byp;
      dr_shift = (m_col(m_s) == 0) && (m_stg(m_s) == SHF);
      dr_upd   = (m_col(m_s) == 0) && (m_stg(m_s) == UPD);
      ext      = (m_ir == 2'b00);
      smp      = (m_ir == 2'b01);
      byp      = !ext && !smp;
      check("m_state", bus.state, m_enc(m_s));
      check("m_shift_dr", bus.shift_dr, dr_shift && !byp);
      check("m_bp_shift", bus.bp_shift, dr_shift && byp);
      check("m_up_enable", bus.up_enable, dr_upd && !byp);
      check("m_mode", bus.mode, ext && (m_s != 0));
      check("m_sel", bus.sel, byp);
      check("m_tdo_ir_sel", bus.tdo_ir_sel, (m_col(m_s) == 1) && (m_stg(m_s) == SHF));
      check("m_ir_tdo", bus.ir_tdo, m_sr[0]);
    end
  end

  task automatic step(input bit r, input bit t, input bit d);
    rst     = r;
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    m_update(r, t, d);
    if (r) m_valid = 1'b1;
    #1;
  endtask

  // From RTI: load a 2-bit opcode and return to RTI.
  task automatic load_ir(input logic [1:0] v);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, v[0]);
    step(0, 1, v[1]);
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  // From RTI: six SHIFT_DR cycles then update, counting control-output cycles.
  task automatic dr_scan(output int n_sd, output int n_bp, output int n_up, output int n_sel0);
    bit seq [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    n_sd = 0; n_bp = 0; n_up = 0; n_sel0 = 0;
    for (int i = 0; i < 11; i++) begin
      step(0, seq[i], 0);
      n_sd   += int'(bus.shift_dr);
      n_bp   += int'(bus.bp_shift);
      n_up   += int'(bus.up_enable);
      n_sel0 += int'(!bus.sel);
    end
  endtask

  initial begin
    int sd, bp, up, sel0, first_tlr;
    n_checks = 0;
    n_errors = 0;
    m_valid  = 1'b0;
    rst      = 1'b0;
    bus.tms  = 1'b0;
    bus.tdi  = 1'b0;
    m_s = 0; m_sr = '0; m_ir = '1;

    // Reset
    step(1, 0, 0);
    check("rst_state", bus.state, 4'hF);
    check("rst_sel", bus.sel, 1);
    check("rst_mode", bus.mode, 0);
    check("rst_shift_dr", bus.shift_dr, 0);
    check("rst_bp_shift", bus.bp_shift, 0);
    check("rst_up_enable", bus.up_enable, 0);
    check("rst_ir_tdo", bus.ir_tdo, 0);
    check("rst_tdo_ir_sel", bus.tdo_ir_sel, 0);
    step(0, 0, 0);
    check("rti_state", bus.state, 4'hC);

    // IR load of EXTEST
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("ir_shift_state", bus.state, 4'hA);
    check("ir_tdo_first", bus.ir_tdo, 1);
    check("ir_tdo_sel", bus.tdo_ir_sel, 1);
    step(0, 0, 0);
    check("ir_tdo_second", bus.ir_tdo, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("upd_ir_state", bus.state, 4'hD);
    step(0, 0, 0);
    check("extest_mode", bus.mode, 1);
    check("extest_sel", bus.sel, 0);

    // EXTEST DR scan
    dr_scan(sd, bp, up, sel0);
    check("extest_shift_cycles", sd, 6);
    check("extest_up_cycles", up, 1);
    check("extest_bp_cycles", bp, 0);

    // SEL_DR -> SEL_IR -> TLR must not update
    up = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      up += int'(bus.up_enable);
    end
    check("selir_tlr_state", bus.state, 4'hF);
    check("selir_tlr_up", up, 0);
    check("selir_tlr_sel", bus.sel, 1);
    step(0, 0, 0);

    // Mid-operation reset under EXTEST
    load_ir(2'b00);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("mid_pre_shift_dr", bus.shift_dr, 1);
    step(1, 1, 0);
    check("mid_state", bus.state, 4'hF);
    check("mid_sel", bus.sel, 1);
    check("mid_mode", bus.mode, 0);
    check("mid_shift_dr", bus.shift_dr, 0);
    check("mid_up", bus.up_enable, 0);
    step(0, 0, 0);
    check("mid_up_after", bus.up_enable, 0);

    // Forced return from SHIFT_DR
    load_ir(2'b00);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    first_tlr = 0;
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0);
      if (first_tlr == 0 && bus.state == 4'hF) first_tlr = i;
    end
    check("force_state", bus.state, 4'hF);
    check("force_within5", (first_tlr >= 1 && first_tlr <= 5), 1);
    check("force_sel", bus.sel, 1);
    check("force_mode", bus.mode, 0);
    step(0, 1, 0);
    check("force_hold_tlr", bus.state, 4'hF);
    step(0, 0, 0);

    // BYPASS DR scan, explicit 11 and the unassigned 10
    load_ir(2'b11);
    dr_scan(sd, bp, up, sel0);
    check("bypass_bp_cycles", bp, 6);
    check("bypass_shift_cycles", sd, 0);
    check("bypass_up_cycles", up, 0);
    check("bypass_sel_low", sel0, 0);
    load_ir(2'b10);
    dr_scan(sd, bp, up, sel0);
    check("op10_bp_cycles", bp, 6);
    check("op10_up_cycles", up, 0);
    load_ir(2'b01);
    dr_scan(sd, bp, up, sel0);
    check("sample_shift_cycles", sd, 6);
    check("sample_up_cycles", up, 1);

    // Random walk
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 4), $urandom_range(0, 1) != 0);
    end

    @(negedge tck);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 The block SHALL have one parameter: IR_W, default 2, instruction register width in bits.
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 tck  input  1  test clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tms  input  1  test mode select; sampled on the rising edge of tck.
REQ-006 tdi  input  1  serial data in, used by the instruction shift chain.
REQ-007 shift_dr  output  1  shift enable to the boundary scan cell chain.
REQ-008 up_enable  output  1  update strobe to the boundary scan cells.
REQ-009 mode  output  1  boundary cell output select: 1 = drive the update latch, 0 = pass through.
REQ-010 sel  output  1  TDO mux select: 1 = bypass register, 0 = boundary chain.
REQ-011 bp_shift  output  1  shift enable to the bypass register.
REQ-012 ir_tdo  output  1  serial out of the instruction shift register (bit 0).
REQ-013 tdo_ir_sel  output  1  high in SHIFT_IR; the chip-level TDO mux selects ir_tdo when high.
REQ-014 state  output  4  current TAP state, for debug and for the bench.

Function
REQ-015 The FSM SHALL implement the 16 IEEE 1149.1 TAP states with the standard tms-driven transitions, one transition per tck.
- States: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR.
REQ-016 Holding tms=1 for 5 consecutive cycles SHALL reach TLR from any state; the FSM then stays in TLR while tms=1.
REQ-017 The IR shift register SHALL behave as follows in each IR state:
- CAP_IR: load binary 0..01 (LSB=1, other bits 0).
- SHIFT_IR: shift right; tdi enters the MSB.
- All other states: hold.
REQ-018 The active IR SHALL load from the shift register on the tck edge leaving UPD_IR, and hold otherwise.
REQ-019 Opcodes SHALL decode as follows:
- 00 EXTEST
- 01 SAMPLE/PRELOAD
- 11 BYPASS
- 10 (unassigned): treated as BYPASS.
REQ-020 The outputs SHALL be Moore outputs, decoded only from the state and active IR, with no direct tms path:
- shift_dr = 1 in SHIFT_DR when the IR is EXTEST or SAMPLE.
- bp_shift = 1 in SHIFT_DR when the IR is BYPASS.
- up_enable = 1 for exactly the single UPD_DR cycle when the IR is EXTEST or SAMPLE.
- mode = 1 when the IR is EXTEST and the state is not TLR.
- sel = 1 when the IR is BYPASS.
- tdo_ir_sel = 1 in SHIFT_IR.
REQ-021 Outputs SHALL change only after a tck rising edge, never within a cycle.
REQ-022 PAUSE_DR and PAUSE_IR SHALL hold all shift registers and deassert shift_dr and bp_shift.
REQ-023 up_enable SHALL NOT assert when the path SEL_DR -> SEL_IR -> TLR is taken.
REQ-024 Entering TLR through tms SHALL load the active IR with BYPASS, identical to reset.

Reset
REQ-025 While rst=1 at a tck edge, the block SHALL set:
- state = TLR
- active IR = all ones (BYPASS)
- IR shift register = 0
REQ-026 After reset, the outputs SHALL be: shift_dr = 0, up_enable = 0, bp_shift = 0, mode = 0, sel = 1, tdo_ir_sel = 0, ir_tdo = 0.
REQ-027 rst SHALL take priority over tms in every state, including mid-shift, and SHALL abort any pending update.

Structure
REQ-028 A shared package jtag_pkg SHALL hold:
- the 4-bit state encoding constants for all 16 states;
- the opcode constants EXTEST, SAMPLE and BYPASS;
- IR_W.
REQ-029 The instruction register (shift stage plus active stage) SHALL be the single sub-module jtag_ir.
REQ-030 The FSM and output decode SHALL remain in jtag_tap_ctrl.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset: rst=1 for 1 cycle -> state=TLR, sel=1, mode=0, shift_dr=0, bp_shift=0, up_enable=0.
- Forced return: from SHIFT_DR, tms=1 for 5 cycles -> TLR, reached within 5 cycles.
- IR load: from RTI, tms=1,1,0,0 -> SHIFT_IR, then tdi=0,0 with tms=0,1, then tms=1,0 -> ir_tdo emits 1 then 0; after UPD_IR, mode=1 and sel=0.
- EXTEST DR scan: SEL_DR, CAP_DR, then 6 cycles in SHIFT_DR (last with tms=1) -> shift_dr=1 for exactly 6 cycles, up_enable=1 for exactly 1 cycle in UPD_DR, bp_shift=0 throughout.
- BYPASS DR scan: the same sequence with IR=11 -> bp_shift=1 for 6 cycles, shift_dr=0 and up_enable=0 throughout, sel=1.
- Mid-operation reset: rst=1 in SHIFT_DR under EXTEST -> next cycle state=TLR, IR=11, shift_dr=0, mode=0, and no up_enable pulse.
